// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add MULTU, restoring DIVU, MTHI/MTLO.
// Define MULDIV_SIGNED_EN to add signed MULT/DIV (op[1]=1) through a sign-fix state.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

`ifdef MULDIV_SIGNED_EN
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;
`else
    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
`endif

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     a_in, b_in;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, div_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 last_iter;
    logic                 need_fix;

`ifdef MULDIV_SIGNED_EN
    logic                 sgn_q, sgn_d, div_op_q, div_op_d;
    logic                 a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic                 a_neg_in, b_neg_in;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // The datapath always works on magnitudes; signs are re-applied in StFix.
    assign a_neg_in = op[1] & rs_val[WIDTH-1];
    assign b_neg_in = op[1] & rt_val[WIDTH-1];
    assign a_in     = a_neg_in ? -rs_val : rs_val;
    assign b_in     = b_neg_in ? -rt_val : rt_val;
    assign need_fix = sgn_q;
    assign prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    assign quo_fix  = (b_q == '0) ? '1 :
                      (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
    logic unused_op_hi;
    assign unused_op_hi = op[1];
    assign a_in         = rs_val;
    assign b_in         = rt_val;
    assign need_fix     = 1'b0;
`endif

    // MUL: acc = {partial product, remaining multiplier bits}.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // DIV: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn_d    = sgn_q;
        div_op_d = div_op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    acc_d   = {{WIDTH{1'b0}}, a_in};
                    b_d     = b_in;
                    cnt_d   = '0;
                    state_d = op[0] ? StDiv : StMul;
`ifdef MULDIV_SIGNED_EN
                    sgn_d    = op[1];
                    div_op_d = op[0];
                    a_neg_d  = a_neg_in;
                    b_neg_d  = b_neg_in;
`endif
                end else if (!start) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            StMul, StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    acc_d = (state_q == StMul) ? mul_next : div_next;
                    cnt_d = cnt_q + 1'b1;
                    if (last_iter) begin
                        cnt_d = '0;
                        if (need_fix) begin
`ifdef MULDIV_SIGNED_EN
                            state_d = StFix;
`endif
                        end else begin
                            state_d = StIdle;
                            hi_d    = acc_d[2*WIDTH-1:WIDTH];
                            lo_d    = acc_d[WIDTH-1:0];
                            done_d  = 1'b1;
                        end
                    end
                end
            end
`ifdef MULDIV_SIGNED_EN
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    hi_d   = div_op_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_d   = div_op_q ? quo_fix : prod_fix[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= 1'b0;
            div_op_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= sgn_d;
            div_op_q <= div_op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: driver pushes expected HI/LO and done cycle, monitor
// pops on every done pulse. Signed checks are compiled only with MULDIV_SIGNED_EN.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  rs_val = '0;
    logic [W-1:0]  rt_val = '0;
    logic          flush = 1'b0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic on the architectural meaning of each op.
    task automatic ref_model(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] rh, output logic [W-1:0] rl, output int lat);
        logic [63:0] p;
        lat = W;
`ifdef MULDIV_SIGNED_EN
        if (opc[1]) begin
            longint sp;
            int     sa, sbv;
            lat = W + 1;
            sa  = a;
            sbv = b;
            if (!opc[0]) begin
                sp = longint'(sa) * longint'(sbv);
                p  = sp;
                rh = p[63:32];
                rl = p[31:0];
            end else if (b == 0) begin
                rl = '1;
                rh = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                rl = 32'h8000_0000;
                rh = '0;
            end else begin
                rl = sa / sbv;
                rh = sa % sbv;
            end
            return;
        end
`endif
        if (!opc[0]) begin
            p  = {32'd0, a} * {32'd0, b};
            rh = p[63:32];
            rl = p[31:0];
        end else if (b == 0) begin
            rl = '1;
            rh = a;
        end else begin
            rl = a / b;
            rh = a % b;
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding (t=%0t)",
                         $time);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_e.due));
                check("hi", {32'd0, hi}, {32'd0, mon_e.hi});
                check("lo", {32'd0, lo}, {32'd0, mon_e.lo});
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({name, "_timeout"}, 64'(busy), 64'(0));
    endtask

    // Launch an op, record the expectation, and hold start for exactly one cycle.
    task automatic launch(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] rh, rl;
        int           lat;
        @(negedge clk);
        ref_model(opc, a, b, rh, rl, lat);
        start  = 1'b1;
        op     = opc;
        rs_val = a;
        rt_val = b;
        sb.push_back('{hi: rh, lo: rl, due: cyc + 1 + lat});
        m_hi = rh;
        m_lo = rl;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 64'(busy), 64'(1));
    endtask

    task automatic run_op(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
        launch(opc, a, b);
        wait_idle("op");
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
    endtask

    task automatic mt_write(input logic whi, input logic wlo, input logic [W-1:0] d);
        @(negedge clk);
        hi_we = whi;
        lo_we = wlo;
        wdata = d;
        if (whi) m_hi = d;
        if (wlo) m_lo = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_hi", {32'd0, hi}, {32'd0, m_hi});
        check("mt_lo", {32'd0, lo}, {32'd0, m_lo});
    endtask

    initial begin
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", {32'd0, hi}, 64'(0));
        check("rst_lo", {32'd0, lo}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        run_op(2'b01, 32'd100, 32'd7);
        check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        run_op(2'b01, 32'h1234, 32'd0);
        check("divu_by_zero", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});

        // Flush mid-multiply: result discarded, HI/LO hold.
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);
        check("flush_hold", {hi, lo}, {m_hi, m_lo});

        // Flush on the final iteration edge also discards the result.
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'd77; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (W - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_last_hold", {hi, lo}, {m_hi, m_lo});

        // Flush in IDLE blocks a coincident start.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; rs_val = 32'd9; rt_val = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_blocks_start", 64'(busy), 64'(0));

        mt_write(1'b0, 1'b1, 32'hA5A5_A5A5);
        mt_write(1'b1, 1'b1, 32'h0BAD_CAFE);

        // Mid-op start and MTLO are ignored.
        launch(2'b00, 32'd1000, 32'd3000);
        repeat (4) @(negedge clk);
        start = 1'b1; rs_val = 32'd7; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b1; wdata = 32'h1111_2222;
        @(negedge clk);
        lo_we = 1'b0;
        wait_idle("ignored");
        repeat (3) @(negedge clk);
        check("ignored_lo", {32'd0, lo}, 64'(32'd3_000_000));
        check("ignored_sb", 64'(sb.size()), 64'(0));

`ifdef MULDIV_SIGNED_EN
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(2'b10, 32'hFFFF_FFFE, 32'd3);
        check("mult_m2_3", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
`else
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        check("op11_is_divu", {hi, lo}, {32'd1, 32'h7FFF_FFFC});
`endif

        for (int i = 0; i < 24; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            int           sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            if (sel == 1) begin ra = '1; rb = '1; end
            if (sel == 2) begin ra = 32'h8000_0000; rb = '1; end
            if (sel == 3) rb = 32'($urandom_range(1, 16));
            run_op(ro, ra, rb);
            if ($urandom_range(0, 3) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        // Asynchronous reset mid-divide clears everything at once.
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'hDEAD_BEEF; rt_val = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_no_result", {hi, lo}, 64'(0));
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
